// File: rtl/inst_queue.sv
// Fetch-to-dispatch instruction FIFO; an entry reaches issue one cycle after enqueue.
// Backpressure: dispatch ready pops the head, and stall holds the PC once SLACK slots remain.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int SLACK = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_inst,
  input  logic                     fetch_pred_taken,
  output logic                     stall,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [31:0]              issue_pc,
  output logic [31:0]              issue_inst,
  output logic                     issue_pred_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SLACK);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          full;
  logic          deq;
  logic          enq;
  logic          drop;
  entry_t        head_entry;

  assign full        = (count == FULL_CNT);
  assign issue_valid = (count != '0);
  assign deq         = issue_valid & issue_ready & ~flush;
  // A full queue can still take a fetch when the head leaves in the same cycle.
  assign enq         = fetch_valid & ~flush & (~full | deq);
  assign drop        = fetch_valid & ~flush & full & ~deq;

  // Decoded from registered occupancy only, so the PC register sees no input-to-output path.
  assign stall = (count >= STALL_CNT);

  assign head_entry       = mem[head];
  assign issue_pc         = head_entry.pc;
  assign issue_inst       = head_entry.inst;
  assign issue_pred_taken = head_entry.pred_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && enq) begin
      mem[tail] <= '{pc: fetch_pc, inst: fetch_inst, pred_taken: fetch_pred_taken};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue at DEPTH=8, SLACK=2 with hand-computed expectations.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_pred_taken;
  logic        stall;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_pc;
  logic [31:0] issue_inst;
  logic        issue_pred_taken;
  logic [3:0]  count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  inst_queue #(.DEPTH(8), .SLACK(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_pred_taken(fetch_pred_taken), .stall(stall),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pc(issue_pc),
    .issue_inst(issue_inst), .issue_pred_taken(issue_pred_taken),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pt);
    fetch_valid      = 1'b1;
    fetch_pc         = pc;
    fetch_inst       = inst;
    fetch_pred_taken = pt;
    step();
    fetch_valid      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [31:0] inst_tab [3];

  initial begin
    inst_tab[0] = 32'h13;
    inst_tab[1] = 32'h93;
    inst_tab[2] = 32'h113;
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    fetch_inst = '0; fetch_pred_taken = 1'b0; issue_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_stall", stall, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;

    // Three pushes, then in-order pops
    for (int i = 0; i < 3; i++) push(32'(4 * i), inst_tab[i], i[0]);
    check("t1_count", count, 3);
    check("t1_stall", stall, 0);
    check("t1_valid", issue_valid, 1);
    check("t1_pc", issue_pc, 32'h0);
    check("t1_inst", issue_inst, 32'h13);
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_pop_pc", issue_pc, 32'(4 * i));
      check("t1_pop_inst", issue_inst, inst_tab[i]);
      check("t1_pop_pt", issue_pred_taken, 32'(i % 2));
      step();
    end
    check("t1_empty_valid", issue_valid, 0);
    check("t1_empty_count", count, 0);
    issue_ready = 1'b0;

    // Fill to stall, to full, then drop
    for (int i = 0; i < 5; i++) push(32'h40 + 32'(4 * i), 32'h1, 1'b0);
    check("t2_stall5", stall, 0);
    push(32'h54, 32'h1, 1'b0);
    check("t2_stall6", stall, 1);
    check("t2_count6", count, 6);
    push(32'h58, 32'h1, 1'b0);
    push(32'h5c, 32'h1, 1'b0);
    check("t2_count8", count, 8);
    check("t2_ovf_before", overflow, 0);
    push(32'h60, 32'h1, 1'b0);
    check("t2_count_drop", count, 8);
    check("t2_ovf", overflow, 1);
    check("t2_head", issue_pc, 32'h40);

    // Full queue with simultaneous push and pop
    do_reset();
    check("t3_rst_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) push(32'h80 + 32'(4 * i), 32'h2, 1'b0);
    check("t3_full", count, 8);
    issue_ready = 1'b1;
    push(32'h1000, 32'h3, 1'b1);
    check("t3_count", count, 8);
    check("t3_ovf", overflow, 0);
    for (int j = 1; j < 8; j++) begin
      check("t3_pop_pc", issue_pc, 32'h80 + 32'(4 * j));
      step();
    end
    check("t3_last_pc", issue_pc, 32'h1000);
    check("t3_last_pt", issue_pred_taken, 1);
    step();
    check("t3_empty", count, 0);

    // Streaming across two pointer wraps
    for (int i = 0; i < 20; i++) begin
      push(32'(4 * i), 32'(i), 1'b0);
      check("t4_pc", issue_pc, 32'(4 * i));
      check("t4_count", count, 1);
      check("t4_stall", stall, 0);
    end
    step();
    check("t4_drain", count, 0);
    issue_ready = 1'b0;

    // Flush discards contents and the concurrent fetch
    for (int i = 0; i < 5; i++) push(32'hc0 + 32'(4 * i), 32'h4, 1'b0);
    check("t5_fill", count, 5);
    flush = 1'b1; issue_ready = 1'b1;
    push(32'h100, 32'h5, 1'b0);
    flush = 1'b0; issue_ready = 1'b0;
    check("t5_count", count, 0);
    check("t5_valid", issue_valid, 0);
    check("t5_stall", stall, 0);
    push(32'h200, 32'h6, 1'b0);
    check("t5_pc", issue_pc, 32'h200);
    check("t5_count1", count, 1);

    // Overflow survives flush, then reset beats flush
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(4 * i), 32'h7, 1'b0);
    check("t6_ovf_set", overflow, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_ovf_flush", overflow, 1);
    check("t6_count_flush", count, 0);
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 32'h8, 1'b0);
    check("t6_count4", count, 4);
    rst = 1'b0; flush = 1'b1;
    step();
    rst = 1'b1; flush = 1'b0;
    check("t6_count", count, 0);
    check("t6_valid", issue_valid, 0);
    check("t6_stall", stall, 0);
    check("t6_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
